// File: rtl/lane_pipe_valid.sv
// lane_pipe_valid: LANES x WIDTH pipeline of DEPTH stages with per-lane valid,
// ready/valid backpressure, bubble collapsing, synchronous flush and occupancy. Rev 1.0
`default_nettype none

module lane_pipe_valid #(
   parameter int LANES = 4,
   parameter int WIDTH = 8,
   parameter int DEPTH = 2,
   parameter int OCC_W = $clog2(DEPTH + 1)
) (
   input  logic                   clkf,
   input  logic                   reset,
   input  logic [LANES*WIDTH-1:0] in_data,
   input  logic [LANES-1:0]       in_valid,
   output logic                   in_ready,
   input  logic                   flush,
   output logic [LANES*WIDTH-1:0] out_data,
   output logic [LANES-1:0]       out_valid,
   input  logic                   out_ready,
   output logic [OCC_W-1:0]       occupancy
);

   localparam int DW = LANES * WIDTH;

   logic [DEPTH-1:0]            sv_q, sv_d;
   logic [DEPTH-1:0][LANES-1:0] mask_q, mask_d;
   logic [DEPTH-1:0][DW-1:0]    data_q, data_d;
   logic [OCC_W-1:0]            occ_q, occ_d;

   logic [DEPTH-1:0] load;
   logic [DW-1:0]    in_masked;
   logic             capture;

   // A stage may load whenever any stage from it to the head is empty or the
   // head is being consumed; out_ready therefore reaches in_ready combinationally.
   always_comb begin : p_load
      logic all_full;
      all_full = 1'b1;
      load     = '0;
      for (int s = DEPTH - 1; s >= 0; s--) begin
         all_full = all_full & sv_q[s];
         load[s]  = out_ready | ~all_full;
      end
   end

   always_comb begin : p_mask
      in_masked = '0;
      for (int l = 0; l < LANES; l++) begin
         if (in_valid[l]) begin
            in_masked[l*WIDTH +: WIDTH] = in_data[l*WIDTH +: WIDTH];
         end
      end
   end

   assign in_ready = ~flush & load[0];
   assign capture  = in_ready & (|in_valid);

   // Empty stages always hold zero mask/data, so shifting a bubble keeps outputs clean.
   always_comb begin : p_next
      sv_d   = sv_q;
      mask_d = mask_q;
      data_d = data_q;
      occ_d  = '0;
      if (flush) begin
         sv_d   = '0;
         mask_d = '0;
         data_d = '0;
      end else begin
         for (int s = 1; s < DEPTH; s++) begin
            if (load[s]) begin
               sv_d[s]   = sv_q[s-1];
               mask_d[s] = mask_q[s-1];
               data_d[s] = data_q[s-1];
            end
         end
         if (load[0]) begin
            sv_d[0]   = capture;
            mask_d[0] = capture ? in_valid : '0;
            data_d[0] = capture ? in_masked : '0;
         end
      end
      for (int s = 0; s < DEPTH; s++) begin
         occ_d = occ_d + OCC_W'(sv_d[s]);
      end
   end

   always_ff @(posedge clkf or negedge reset) begin
      if (!reset) begin
         sv_q   <= '0;
         mask_q <= '0;
         data_q <= '0;
         occ_q  <= '0;
      end else begin
         sv_q   <= sv_d;
         mask_q <= mask_d;
         data_q <= data_d;
         occ_q  <= occ_d;
      end
   end

   assign out_valid = {LANES{sv_q[DEPTH-1]}} & mask_q[DEPTH-1];
   assign out_data  = data_q[DEPTH-1];
   assign occupancy = occ_q;

endmodule

`default_nettype wire

// File: tb/tb_lane_pipe_valid.sv
// tb_lane_pipe_valid: scoreboard bench for lane_pipe_valid (LANES=4, WIDTH=8, DEPTH=2).
`default_nettype none

module tb_lane_pipe_valid;

   localparam int LANES = 4;
   localparam int WIDTH = 8;
   localparam int DEPTH = 2;
   localparam int OCC_W = $clog2(DEPTH + 1);
   localparam int DW    = LANES * WIDTH;

   typedef struct packed {
      logic [LANES-1:0] m;
      logic [DW-1:0]    d;
   } beat_t;

   logic             clkf = 1'b0;
   logic             reset;
   logic [DW-1:0]    in_data;
   logic [LANES-1:0] in_valid;
   logic             in_ready;
   logic             flush;
   logic [DW-1:0]    out_data;
   logic [LANES-1:0] out_valid;
   logic             out_ready;
   logic [OCC_W-1:0] occupancy;

   int               n_tests = 0;
   int               n_fail  = 0;
   beat_t            sb[$];
   logic [DEPTH-1:0] m_sv = '0;

   lane_pipe_valid #(
      .LANES(LANES),
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
   ) dut (
      .clkf     (clkf),
      .reset    (reset),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .flush    (flush),
      .out_data (out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .occupancy(occupancy)
   );

   always #5 clkf = ~clkf;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] mask_data(input logic [LANES-1:0] m, input logic [DW-1:0] d);
      logic [DW-1:0] r;
      r = '0;
      for (int l = 0; l < LANES; l++) begin
         if (m[l]) r[l*WIDTH +: WIDTH] = d[l*WIDTH +: WIDTH];
      end
      return r;
   endfunction

   // One clock cycle: drive, check mid-cycle, update scoreboard and slot model.
   task automatic cyc(input logic fl, input logic [LANES-1:0] iv, input logic [DW-1:0] id,
                      input logic ordy);
      beat_t            hd;
      logic             exp_rdy, acc, xfer, full_run;
      logic [DEPTH-1:0] ld, nsv;
      flush     = fl;
      in_valid  = iv;
      in_data   = id;
      out_ready = ordy;
      #4;
      exp_rdy = !fl && (ordy || !(&m_sv));
      hd      = (m_sv[DEPTH-1] && sb.size() > 0) ? sb[0] : '0;
      check("in_ready", 64'(in_ready), 64'(exp_rdy));
      check("out_valid", 64'(out_valid), 64'(hd.m));
      check("out_data", 64'(out_data), 64'(hd.d));
      check("occupancy", 64'(occupancy), 64'($countones(m_sv)));
      xfer = ordy && m_sv[DEPTH-1];
      acc  = exp_rdy && (|iv);
      if (xfer && sb.size() > 0) void'(sb.pop_front());
      if (acc) sb.push_back(beat_t'{m: iv, d: mask_data(iv, id)});
      full_run = 1'b1;
      for (int s = DEPTH - 1; s >= 0; s--) begin
         full_run = full_run & m_sv[s];
         ld[s]    = ordy | ~full_run;
      end
      nsv[0] = ld[0] ? acc : m_sv[0];
      for (int s = 1; s < DEPTH; s++) nsv[s] = ld[s] ? m_sv[s-1] : m_sv[s];
      if (fl) begin
         nsv = '0;
         sb.delete();
      end
      @(posedge clkf);
      m_sv = nsv;
      #1;
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
      check({tag, "_out_data"}, 64'(out_data), 64'(0));
      check({tag, "_occupancy"}, 64'(occupancy), 64'(0));
      check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
   endtask

   initial begin
      reset     = 1'b0;
      flush     = 1'b0;
      in_valid  = '0;
      in_data   = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge clkf);
      #1;
      check_cleared("reset");
      #3 reset = 1'b1;
      @(posedge clkf);
      #1;

      // Streaming, two full beats back to back
      cyc(1'b0, 4'hF, 32'h11223344, 1'b1);
      cyc(1'b0, 4'hF, 32'h55667788, 1'b1);
      check("stream_b0", 64'(out_data), 64'h11223344);
      cyc(1'b0, 4'h0, 32'h0, 1'b1);
      cyc(1'b0, 4'h0, 32'h0, 1'b1);
      cyc(1'b0, 4'h0, 32'h0, 1'b1);

      // Partial lane mask
      cyc(1'b0, 4'b0101, 32'hAABBCCDD, 1'b1);
      cyc(1'b0, 4'h0, 32'h0, 1'b1);
      check("partial_valid", 64'(out_valid), 64'h5);
      check("partial_data", 64'(out_data), 64'h00BB00DD);
      cyc(1'b0, 4'h0, 32'h0, 1'b1);

      // Backpressure: third beat refused until out_ready rises
      cyc(1'b0, 4'hF, 32'hA1A1A1A1, 1'b0);
      cyc(1'b0, 4'hF, 32'hA2A2A2A2, 1'b0);
      cyc(1'b0, 4'hF, 32'hA3A3A3A3, 1'b0);
      check("bp_occ", 64'(occupancy), 64'd2);
      cyc(1'b0, 4'hF, 32'hA3A3A3A3, 1'b1);
      repeat (3) cyc(1'b0, 4'h0, 32'h0, 1'b1);
      check("bp_drain_occ", 64'(occupancy), 64'd0);

      // Bubble collapse
      cyc(1'b0, 4'hF, 32'hB1B1B1B1, 1'b0);
      cyc(1'b0, 4'h0, 32'h0, 1'b0);
      cyc(1'b0, 4'hF, 32'hB2B2B2B2, 1'b0);
      check("bubble_occ", 64'(occupancy), 64'd2);
      check("bubble_head", 64'(out_valid), 64'hF);
      repeat (3) cyc(1'b0, 4'h0, 32'h0, 1'b1);

      // Flush with a full pipe and input offered
      cyc(1'b0, 4'hF, 32'hC1C1C1C1, 1'b0);
      cyc(1'b0, 4'hF, 32'hC2C2C2C2, 1'b0);
      cyc(1'b1, 4'hF, 32'hC3C3C3C3, 1'b1);
      check("flush_occ", 64'(occupancy), 64'd0);
      check("flush_valid", 64'(out_valid), 64'd0);
      cyc(1'b0, 4'h0, 32'h0, 1'b1);

      // Asynchronous reset mid-stream
      cyc(1'b0, 4'hF, 32'hD1D1D1D1, 1'b0);
      cyc(1'b0, 4'hF, 32'hD2D2D2D2, 1'b0);
      reset     = 1'b0;
      in_valid  = '0;
      out_ready = 1'b0;
      #1;
      check_cleared("midrst");
      m_sv = '0;
      sb.delete();
      #3 reset = 1'b1;
      @(posedge clkf);
      #1;
      cyc(1'b0, 4'hF, 32'hE1E1E1E1, 1'b1);
      cyc(1'b0, 4'h0, 32'h0, 1'b1);
      cyc(1'b0, 4'h0, 32'h0, 1'b1);

      // Random traffic
      for (int i = 0; i < 300; i++) begin
         cyc(($urandom_range(0, 15) == 0),
             ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15)),
             32'($urandom),
             ($urandom_range(0, 2) != 0));
      end
      repeat (DEPTH + 1) cyc(1'b0, 4'h0, 32'h0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/lane_pipe_valid.md
# lane_pipe_valid

Parametrised multi-lane pipeline register with per-lane valid, ready/valid backpressure, bubble collapsing and synchronous flush. It carries LANES parallel lanes of WIDTH bits through DEPTH register stages between physical-layer sub-blocks, such as byte striping and the per-lane scramblers. It extends the fixed 4-lane, 1-bit, single-stage flop bank with configurable width and depth, stall handling and an occupancy count.

## Interface
- LANES, 4, number of lanes (≥1)
- WIDTH, 8, bits per lane (≥1)
- DEPTH, 2, pipeline stages (≥1)
- OCC_W, $clog2(DEPTH+1), occupancy counter width (derived, not overridden)

- clkf  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; low clears all state immediately
- in_data  in  LANES*WIDTH  lane l at [l*WIDTH +: WIDTH]
- in_valid  in  LANES  per-lane valid mask of the input beat
- in_ready  out  1  pipeline accepts a beat this cycle
- flush  in  1  synchronous discard of all held beats
- out_data  out  LANES*WIDTH  lane data of the head beat
- out_valid  out  LANES  per-lane valid of the head beat
- out_ready  in  1  downstream consumes the head beat
- occupancy  out  OCC_W  number of occupied stages (0..DEPTH)

## Operation
- Beat: one LANES-wide data word plus its lane mask. A beat exists when |in_valid = 1.
- Each stage s (0 = input side, DEPTH-1 = head) holds a slot flag sv[s], a mask and data.
- Capture into stage 0: in_ready && |in_valid && !flush. Lanes with in_valid[l] = 0 are stored as data 0 and mask 0.
- Advance rules:
  - Head frees when out_ready = 1.
  - Stage s loads from stage s-1 when sv[s] = 0 or stage s frees that cycle.
  - A loaded stage takes sv, mask and data from stage s-1.
  - Bubbles collapse: an empty stage never blocks a following beat.
- in_ready = !flush && (!sv[0] || stage 0 frees). The path from out_ready is combinational through the chain and is documented as such.
- out_valid[l] = sv[DEPTH-1] & mask[l]. out_data is driven from the head registers, and lanes with mask 0 read 0.
- A transfer occurs when out_ready && sv[DEPTH-1].
- flush = 1: on the next edge all sv, masks and data clear to 0 and occupancy goes to 0. A head beat transferred in the flush cycle counts as delivered. No input is captured while flush = 1.
- occupancy is a registered popcount of sv, updated every edge consistently with the sv updates.
- Reset low, at any time including mid-stream: all sv, mask and data are cleared asynchronously. Outputs become out_valid = 0, out_data = 0, occupancy = 0, and in_ready = 1 (flush low). Operation resumes on the first edge after release.

## Timing
- Latency with no stall: a beat captured at edge n appears at the outputs after edge n+DEPTH-1, i.e. DEPTH cycles from in_valid to out_valid.
- Throughput is 1 beat/cycle while out_ready = 1.
- Full condition: all sv = 1 and out_ready = 0. in_ready = 0, contents hold, occupancy = DEPTH.
- Empty condition: occupancy = 0, out_valid = 0, in_ready = 1.
- Full with out_ready = 1: accept and deliver in the same cycle; occupancy stays at DEPTH.
- A stalled head holds out_data and out_valid stable until out_ready.
- in_valid = 0 on all lanes: nothing is captured, and a bubble enters if stage 0 advances.
- DEPTH = 1: a single stage; in_ready = !flush && (!sv[0] || out_ready).

## Test plan
- Reset/idle: hold reset low, then release -> out_valid = 0, out_data = 0, occupancy = 0, in_ready = 1. Assert reset mid-stream with 2 beats held -> all outputs clear immediately, without waiting for a clock edge.
- Streaming (LANES=4, WIDTH=8, DEPTH=2): send beats 0x11223344, 0x55667788 with mask 4'hF and out_ready = 1 -> each beat appears 2 cycles later, in order, one per cycle.
- Partial mask: send data 0xAABBCCDD with mask 4'b0101 -> out_valid = 4'b0101, out_data = 0x00BB00DD.
- Backpressure: out_ready = 0 while 3 beats are offered -> 2 accepted, occupancy = 2, in_ready = 0, head stable. Then raise out_ready -> in_ready = 1 the same cycle, and all 3 beats are delivered in order with none lost.
- Bubble collapse: send beat, gap, beat with out_ready = 0 -> occupancy = 2 after 3 cycles, with no empty slot at the head.
- Flush: occupancy = 2 and out_ready = 1, pulse flush with in_valid = 4'hF -> the head beat is delivered that cycle, the input is not captured, and the next cycle has occupancy = 0 and out_valid = 0.
